// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: shared CPU register bus seen by two masters and the arbiter.
//   slave  modport : the arbiter's view (takes master requests, drives the bus)
//   master modport : the environment's view (raises requests, supplies bus_data_i)
// Signals: m0/m1 req/we/addr/wdata in, m0/m1 ack/rdata out, bus_addr/data/we/rd out,
//          bus_data_i in, grant_o and busy_o status out.
interface cpu_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_we_o;
  logic              bus_rd_o;
  logic [DATA_W-1:0] bus_data_i;

  logic              grant_o;
  logic              busy_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  bus_data_i,
    output m0_ack_o, m0_rdata_o, m1_ack_o, m1_rdata_o,
    output bus_addr_o, bus_data_o, bus_we_o, bus_rd_o,
    output grant_o, busy_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output bus_data_i,
    input  m0_ack_o, m0_rdata_o, m1_ack_o, m1_rdata_o,
    input  bus_addr_o, bus_data_o, bus_we_o, bus_rd_o,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: serialises single-word read/write transactions from two masters
// onto the shared CPU register bus, with one-cycle strobes, a fixed read latency
// (RD_LATENCY, 1..15) and a one-cycle ack back to the granted master.
// Ports: clk_i, reset_i (async, active-high), bus (cpu_bus_arbiter_if.slave).
// Option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise master 0
// has fixed priority over master 1.
// All outputs are registered.
module cpu_bus_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  cpu_bus_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_any;
  logic              win;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_rd_q, bus_rd_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  assign req_any = bus.m0_req_i | bus.m1_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Last winner; resets to 1 so master 0 is preferred first.
  logic last_q;

  always_comb win = (bus.m0_req_i && bus.m1_req_i) ? ~last_q : bus.m1_req_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                          last_q <= 1'b1;
    else if (state_q == S_IDLE && req_any) last_q <= win;
  end
`else
  // Fixed priority: master 1 wins only when master 0 is not requesting.
  always_comb win = ~bus.m0_req_i;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = S_ISSUE;
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; strobes/acks are set one cycle ahead of their state.
  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    bus_we_d = 1'b0;
    bus_rd_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d  = win;
          we_d     = win ? bus.m1_we_i    : bus.m0_we_i;
          addr_d   = win ? bus.m1_addr_i  : bus.m0_addr_i;
          data_d   = win ? bus.m1_wdata_i : bus.m0_wdata_i;
          bus_we_d = we_d;
          bus_rd_d = ~we_d;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          ack0_d = ~grant_q;
          ack1_d = grant_q;
        end
      end
      S_WAIT: begin
        // Last latency cycle: read mux output is valid now.
        if (cnt_q == '0) begin
          ack0_d = ~grant_q;
          ack1_d = grant_q;
          if (grant_q) rdata1_d = bus.bus_data_i;
          else         rdata0_d = bus.bus_data_i;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset clears strobes and acks immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      grant_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      bus_we_q <= 1'b0;
      bus_rd_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      bus_we_q <= bus_we_d;
      bus_rd_q <= bus_rd_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.bus_addr_o = addr_q;
  assign bus.bus_data_o = data_q;
  assign bus.bus_we_o   = bus_we_q;
  assign bus.bus_rd_o   = bus_rd_q;
  assign bus.grant_o    = grant_q;
  assign bus.busy_o     = busy_q;
  assign bus.m0_ack_o   = ack0_q;
  assign bus.m1_ack_o   = ack1_q;
  assign bus.m0_rdata_o = rdata0_q;
  assign bus.m1_rdata_o = rdata1_q;

endmodule
